store_unit: RTL and testbench
=============================

# store_unit

Store-path formatter and write buffer for the pipelined core, the write-side counterpart of the load-extension logic. Accepts SB/SH/SW requests from the MEM stage, replicates store data onto the correct byte lanes, generates byte enables, flags misaligned or illegal stores, and queues well-formed stores in a small FIFO. The FIFO drains to the data-memory port over a req/gnt handshake. `bufEmpty` tells the pipeline when all stores have retired, for load ordering and fences.

## Interface
- `DEPTH`, 2: store-buffer entries; power of two, 2..8.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `storeValid` input 1: MEM stage presents a store this cycle.
- `storeReady` output 1: unit can accept a store this cycle.
- `funct3` input 3: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- `addr` input 32: byte address of the store.
- `dataIn` input 32: rs2 value, with data in the low bits.
- `misaligned` output 1: one-cycle pulse, registered; the accepted store was misaligned or illegal.
- `badAddr` output 32: `addr` of the last faulting store; holds until the next fault.
- `memReq` output 1: write request to data memory.
- `memAddr` output 32: word address, with `[1:0]` always 00.
- `memWdata` output 32: lane-replicated write data.
- `memBe` output 4: byte enables; bit i covers `memWdata[8i+7:8i]`.
- `memGnt` input 1: memory accepts the current request.
- `bufEmpty` output 1: FIFO holds no entries.

## Operation
- **Accept:** a store is accepted on a rising edge where `storeValid && storeReady`.
- **Ready:** `storeReady = !full && rst_n`. There is no push-on-pop when full. A same-cycle pop does not free a slot for that cycle.
- **Formatting**, with `a = addr[1:0]`:
  - SB: `memBe = 4'b0001 << a`; `memWdata = {4{dataIn[7:0]}}`.
  - SH, `a[1]=0`: `memBe = 0011`. SH, `a[1]=1`: `memBe = 1100`. In both cases `memWdata = {2{dataIn[15:0]}}`.
  - SW: `memBe = 1111`; `memWdata = dataIn`.
  - `memAddr = {addr[31:2], 2'b00}`.
- **Faults:** a fault is SH with `a[0]=1`, SW with `a != 00`, or any illegal `funct3`.
  - A faulting store is accepted, meaning the handshake completes.
  - It is not enqueued.
  - `misaligned` is 1 in the following cycle, and `badAddr` is loaded with `addr`.
- **FIFO:** circular buffer of DEPTH entries `{wordAddr[29:0], wdata[31:0], be[3:0]}`.
  - Read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
  - The occupancy counter runs 0..DEPTH.
  - `full = (count == DEPTH)`; `bufEmpty = (count == 0)`.
- **Drain:** `memReq = !bufEmpty`. `memAddr`/`memWdata`/`memBe` are driven from the head entry.
  - The head and its outputs stay stable while `memReq && !memGnt`.
  - On `memReq && memGnt` the head pops.
- **Simultaneous push and pop** (0 < count < DEPTH): count is unchanged and both pointers advance.
- **Pop when count==1 with a simultaneous push:** `memReq` stays 1 and the new entry becomes the head in the next cycle.
- **`memGnt` while `memReq=0`:** ignored.
- **Ordering:** stores are written strictly in acceptance order.

## Timing
- **Reset:** while `rst_n=0` at a rising edge, the following are cleared:
  - count and pointers;
  - `misaligned=0`, `badAddr=0`, `memReq=0`, `memAddr=0`, `memWdata=0`, `memBe=0`;
  - `bufEmpty=1`.
  - `storeReady` is 0 combinationally while `rst_n=0`.
  - Reset mid-drain discards all queued stores, even if `memReq` was pending; no request is reissued.
- **Latency:** a store accepted at edge N has `memReq=1` after edge N if the FIFO was empty. A fault pulse appears after edge N and lasts one cycle.
- **Throughput:** with `memGnt` tied to 1, the unit sustains one store per cycle and `storeReady` never drops.
- **Back-pressure:** with `memGnt=0`, DEPTH stores fill the buffer. `storeReady` falls after the DEPTH-th accept and rises after the first grant.

## Test plan
- **Byte-lane replication:** SB at `addr=0x1003`, `dataIn=0xAABBCCDD` -> `memAddr=0x1000`, `memBe=1000`, `memWdata=0xDDDDDDDD`, `memReq=1` one cycle after accept.
- **SH/SW formatting:**
  - SH at `0x2002`, `dataIn=0x12345678` -> `memBe=1100`, `memWdata=0x56785678`.
  - SW at `0x2004` -> `memBe=1111`, `memWdata=0x12345678`.
- **Faults:**
  - SW at `0x3001` -> `misaligned=1` for exactly one cycle, `badAddr=0x3001`, `bufEmpty` stays 1, `memReq` stays 0.
  - `funct3=011` -> same behaviour.
- **Back-pressure and wrap:** with `DEPTH=2` and `memGnt=0`, push 3 stores -> `storeReady=0` after 2 accepts. Then assert `memGnt` and push continuously for 8 stores -> all memory writes appear in acceptance order through pointer wrap.
- **Simultaneous push/pop:** at count=1 with `memGnt=1` and a push -> count stays 1 and `memAddr` advances to the new entry's address next cycle.
- **Reset mid-drain:** 2 entries queued, `memGnt=0`, assert `rst_n=0` for one edge -> `memReq=0`, `bufEmpty=1`, `storeReady=1` after release, and no stale write is issued.

Source files
------------

// File: rtl/store_unit.sv
// Store-path formatter and write buffer: lane-replicates SB/SH/SW data, flags
// misaligned or illegal stores, and queues good stores for the memory port.
module store_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        storeValid,
  output logic        storeReady,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic        misaligned,
  output logic [31:0] badAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memGnt,
  output logic        bufEmpty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [29:0]   word_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]  lane;
  logic        fault;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic        full, accept, push, pop;

  always_comb begin
    lane      = addr[1:0];
    fault     = 1'b0;
    fmt_be    = 4'b0000;
    fmt_wdata = 32'h0;
    case (funct3)
      3'b000: begin
        fmt_be    = 4'b0001 << lane;
        fmt_wdata = {4{dataIn[7:0]}};
      end
      3'b001: begin
        fault     = lane[0];
        fmt_be    = lane[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{dataIn[15:0]}};
      end
      3'b010: begin
        fault     = (lane != 2'b00);
        fmt_be    = 4'b1111;
        fmt_wdata = dataIn;
      end
      default: fault = 1'b1;
    endcase
  end

  assign full       = (count == CW'(DEPTH));
  assign bufEmpty   = (count == '0);
  assign storeReady = !full && rst_n;
  assign accept     = storeValid && storeReady;
  assign push       = accept && !fault;
  assign memReq     = !bufEmpty;
  assign pop        = memReq && memGnt;

  // Outputs read as zero when the buffer is empty so reset leaves them cleared.
  assign memAddr  = bufEmpty ? 32'h0 : {word_q[rd_ptr], 2'b00};
  assign memWdata = bufEmpty ? 32'h0 : wdata_q[rd_ptr];
  assign memBe    = bufEmpty ? 4'h0  : be_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr]  <= addr[31:2];
      wdata_q[wr_ptr] <= fmt_wdata;
      be_q[wr_ptr]    <= fmt_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
      badAddr    <= 32'h0;
    end else begin
      misaligned <= accept && fault;
      if (accept && fault) badAddr <= addr;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_store_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        storeValid;
  logic        storeReady;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic        misaligned;
  logic [31:0] badAddr;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memGnt;
  logic        bufEmpty;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .storeValid(storeValid), .storeReady(storeReady),
    .funct3(funct3), .addr(addr), .dataIn(dataIn), .misaligned(misaligned),
    .badAddr(badAddr), .memReq(memReq), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memGnt(memGnt), .bufEmpty(bufEmpty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  entry_t      model_q[$];
  logic        exp_mis;
  logic [31:0] exp_bad;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, model the rising edge,
  // then compare every output at the next falling edge.
  task automatic cyc(input logic v, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic g, input logic r);
    bit     ready, acc, bad, pop_m;
    entry_t e;
    int     lane;
    storeValid = v; funct3 = f; addr = a; dataIn = d; memGnt = g; rst_n = r;
    #1;
    ready = r && (model_q.size() < DEPTH);
    chk("storeReady", {31'h0, storeReady}, {31'h0, ready});
    lane = int'(a % 4);
    bad  = 1'b0;
    e.waddr = a - 32'(lane);
    if (f == 3'd0) begin
      e.be = 4'(1 << lane); e.wdata = (d & 32'hFF) * 32'h01010101;
    end else if (f == 3'd1) begin
      bad = (lane % 2) != 0;
      e.be = (lane >= 2) ? 4'b1100 : 4'b0011; e.wdata = (d & 32'hFFFF) * 32'h00010001;
    end else if (f == 3'd2) begin
      bad = lane != 0; e.be = 4'b1111; e.wdata = d;
    end else begin
      bad = 1'b1; e.be = 4'b0000; e.wdata = 32'h0;
    end
    @(posedge clk);
    if (!r) begin
      model_q.delete(); exp_mis = 1'b0; exp_bad = 32'h0;
    end else begin
      acc   = v && ready;
      pop_m = (model_q.size() > 0) && g;
      exp_mis = acc && bad;
      if (acc && bad) exp_bad = a;
      if (pop_m) void'(model_q.pop_front());
      if (acc && !bad) model_q.push_back(e);
    end
    @(negedge clk);
    chk("misaligned", {31'h0, misaligned}, {31'h0, exp_mis});
    chk("badAddr", badAddr, exp_bad);
    chk("bufEmpty", {31'h0, bufEmpty}, {31'h0, model_q.size() == 0});
    chk("memReq", {31'h0, memReq}, {31'h0, model_q.size() != 0});
    if (model_q.size() != 0) begin
      chk("memAddr", memAddr, model_q[0].waddr);
      chk("memWdata", memWdata, model_q[0].wdata);
      chk("memBe", {28'h0, memBe}, {28'h0, model_q[0].be});
    end else begin
      chk("memAddr_idle", memAddr, 32'h0);
      chk("memWdata_idle", memWdata, 32'h0);
      chk("memBe_idle", {28'h0, memBe}, 32'h0);
    end
  endtask

  initial begin
    storeValid = 0; funct3 = 0; addr = 0; dataIn = 0; memGnt = 0; rst_n = 0;
    exp_mis = 0; exp_bad = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_memReq", {31'h0, memReq}, 32'h0);
    chk("reset_bufEmpty", {31'h0, bufEmpty}, 32'h1);

    // Byte-lane replication, then drain
    cyc(1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 1);
    chk("sb_addr", memAddr, 32'h0000_1000);
    chk("sb_be", {28'h0, memBe}, 32'h8);
    chk("sb_data", memWdata, 32'hDDDD_DDDD);
    cyc(0, 0, 0, 0, 1, 1);

    // SH / SW formatting
    cyc(1, 3'b001, 32'h0000_2002, 32'h1234_5678, 0, 1);
    chk("sh_be", {28'h0, memBe}, 32'hC);
    chk("sh_data", memWdata, 32'h5678_5678);
    cyc(1, 3'b010, 32'h0000_2004, 32'h1234_5678, 1, 1);
    chk("sw_be", {28'h0, memBe}, 32'hF);
    chk("sw_data", memWdata, 32'h1234_5678);
    cyc(0, 0, 0, 0, 1, 1);

    // Faults: misaligned SW and illegal funct3
    cyc(1, 3'b010, 32'h0000_3001, 32'h1, 0, 1);
    chk("fault_pulse", {31'h0, misaligned}, 32'h1);
    chk("fault_bad", badAddr, 32'h0000_3001);
    cyc(0, 0, 0, 0, 0, 1);
    chk("fault_one_cycle", {31'h0, misaligned}, 32'h0);
    cyc(1, 3'b011, 32'h0000_4000, 32'h2, 0, 1);
    chk("illegal_pulse", {31'h0, misaligned}, 32'h1);
    cyc(0, 0, 0, 0, 0, 1);

    // Back-pressure and wrap
    for (int i = 0; i < 3; i++) cyc(1, 3'b010, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 0, 1);
    chk("bp_ready_low", {31'h0, storeReady}, 32'h0);
    for (int i = 0; i < 8; i++) cyc(1, 3'b010, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1);

    // Simultaneous push/pop at count 1
    cyc(1, 3'b010, 32'h500, 32'h5, 0, 1);
    cyc(1, 3'b010, 32'h504, 32'h6, 1, 1);
    chk("pushpop_addr", memAddr, 32'h504);
    cyc(0, 0, 0, 0, 1, 1);

    // Reset mid-drain
    cyc(1, 3'b010, 32'h600, 32'h7, 0, 1);
    cyc(1, 3'b010, 32'h604, 32'h8, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("rst_drain_req", {31'h0, memReq}, 32'h0);
    chk("rst_drain_ready", {31'h0, storeReady}, 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cyc(1'($urandom_range(0, 1)), f, $urandom, $urandom,
          1'($urandom_range(0, 2) != 0), $urandom_range(0, 60) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
